usb_bulk_in_fifo: RTL and testbench

USB_BULK_IN_FIFO -- requirements
Module: usb_bulk_in_fifo

---
 rtl/usb_bulk_in_fifo.sv | 153 +++++++++++++++
 tb/tb_usb_bulk_in_fifo.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bulk_in_fifo.sv
// Packet FIFO feeding a USB bulk-IN endpoint. Packets become readable only once
// committed, and the bytes of a sent packet stay held until the host ACKs it.
module usb_bulk_in_fifo #(
    parameter int unsigned ABITS      = 11,
    parameter int unsigned MAX_PACKET = 512
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_tvalid_i,
    output logic           s_tready_o,
    input  logic           s_tlast_i,
    input  logic [7:0]     s_tdata_i,
    output logic           has_data_o,
    output logic           m_tvalid_o,
    input  logic           m_tready_i,
    output logic           m_tlast_o,
    output logic [7:0]     m_tdata_o,
    input  logic           ack_i,
    input  logic           retry_i,
    output logic [ABITS:0] pkt_count_o
);
    localparam int unsigned DEPTH = 2 ** ABITS;

    typedef enum logic [1:0] {StIdle, StPrefetch, StSend, StWait} state_e;

    logic [8:0]       mem [DEPTH];
    state_e           state_q, state_d;
    logic [ABITS:0]   wr_ptr_q, wr_ptr_d;
    logic [ABITS:0]   wr_cmt_q, wr_cmt_d;
    logic [ABITS:0]   rd_ptr_q, rd_ptr_d;
    logic [ABITS:0]   rd_cmt_q, rd_cmt_d;
    logic [ABITS:0]   pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic [ABITS:0]   fill;
    logic             wr_en, wr_eop, commit, ack_take, advance;
    logic [ABITS-1:0] rd_addr;
    logic [8:0]       rd_word;

    // Space is only reclaimed at rd_cmt, so an un-ACKed packet is never overwritten.
    assign fill       = wr_ptr_q - rd_cmt_q;
    assign s_tready_o = (fill < (ABITS + 1)'(DEPTH));
    assign wr_en      = s_tvalid_i & s_tready_o;
    assign wr_eop     = s_tlast_i | (byte_cnt_q == 16'(MAX_PACKET - 1));
    assign commit     = wr_en & wr_eop;
    assign ack_take   = (state_q == StWait) & ack_i & ~retry_i;

    // Look one byte ahead on an accepted non-last beat so SEND streams without bubbles.
    assign advance = (state_q == StSend) & m_tready_i & ~m_last_q & ~retry_i;
    assign rd_addr = rd_ptr_q[ABITS-1:0] + ABITS'(advance);
    assign rd_word = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ABITS-1:0]] <= {wr_eop, s_tdata_i};
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        wr_cmt_d   = wr_cmt_q;
        byte_cnt_d = byte_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (wr_en) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            byte_cnt_d = wr_eop ? '0 : byte_cnt_q + 1'b1;
            if (wr_eop) begin
                wr_cmt_d = wr_ptr_q + 1'b1;
            end
        end
        case ({commit, ack_take})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        rd_cmt_d = rd_cmt_q;
        m_data_d = m_data_q;
        m_last_d = m_last_q;
        case (state_q)
            StIdle: begin
                if ((pkt_cnt_q != '0) && (rd_ptr_q != wr_cmt_q)) begin
                    state_d = StPrefetch;
                end
            end
            StPrefetch: begin
                {m_last_d, m_data_d} = rd_word;
                state_d              = StSend;
            end
            StSend: begin
                if (retry_i) begin
                    rd_ptr_d = rd_cmt_q;
                    m_last_d = 1'b0;
                    state_d  = StIdle;
                end else if (m_tready_i) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (m_last_q) begin
                        m_last_d = 1'b0;
                        state_d  = StWait;
                    end else begin
                        {m_last_d, m_data_d} = rd_word;
                    end
                end
            end
            StWait: begin
                if (retry_i) begin
                    rd_ptr_d = rd_cmt_q;
                    state_d  = StIdle;
                end else if (ack_i) begin
                    rd_cmt_d = rd_ptr_q;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            wr_cmt_q   <= '0;
            rd_ptr_q   <= '0;
            rd_cmt_q   <= '0;
            pkt_cnt_q  <= '0;
            byte_cnt_q <= '0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_cmt_q   <= wr_cmt_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_cmt_q   <= rd_cmt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
        end
    end

    assign has_data_o  = (pkt_cnt_q != '0) && (state_q == StIdle);
    assign m_tvalid_o  = (state_q == StSend);
    assign m_tlast_o   = m_last_q;
    assign m_tdata_o   = m_data_q;
    assign pkt_count_o = pkt_cnt_q;

endmodule

// File: tb/tb_usb_bulk_in_fifo.sv
// Scoreboarded bench: a packetising model feeds an expected-byte queue that a
// monitor drains on every output handshake, replaying un-ACKed bytes on retry.
module tb_usb_bulk_in_fifo;
    localparam int MAXP = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid_i, s_tready_o, s_tlast_i;
    logic [7:0]  s_tdata_i;
    logic        has_data_o, m_tvalid_o, m_tready_i, m_tlast_o;
    logic [7:0]  m_tdata_o;
    logic        ack_i, retry_i;
    logic [11:0] pkt_count_o;

    logic        sm_s_tvalid, sm_s_tready, sm_s_tlast, sm_has_data;
    logic [7:0]  sm_s_tdata, sm_m_tdata;
    logic        sm_m_tvalid, sm_m_tready, sm_m_tlast, sm_ack, sm_retry;
    logic [4:0]  sm_pkt_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] infl_q[$];
    bit         awaiting   = 1'b0;
    int         acked_pkts = 0;
    int         ref_len    = 0;

    int rdy_pct = 100;
    bit rdy_pat = 1'b0;

    usb_bulk_in_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tvalid_i (s_tvalid_i),
        .s_tready_o (s_tready_o),
        .s_tlast_i  (s_tlast_i),
        .s_tdata_i  (s_tdata_i),
        .has_data_o (has_data_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .m_tlast_o  (m_tlast_o),
        .m_tdata_o  (m_tdata_o),
        .ack_i      (ack_i),
        .retry_i    (retry_i),
        .pkt_count_o(pkt_count_o)
    );

    usb_bulk_in_fifo #(.ABITS(4), .MAX_PACKET(8)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tvalid_i (sm_s_tvalid),
        .s_tready_o (sm_s_tready),
        .s_tlast_i  (sm_s_tlast),
        .s_tdata_i  (sm_s_tdata),
        .has_data_o (sm_has_data),
        .m_tvalid_o (sm_m_tvalid),
        .m_tready_i (sm_m_tready),
        .m_tlast_o  (sm_m_tlast),
        .m_tdata_o  (sm_m_tdata),
        .ack_i      (sm_ack),
        .retry_i    (sm_retry),
        .pkt_count_o(sm_pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference packetiser: a byte ends a USB packet on tlast or at MAXP bytes.
    task automatic put(input logic [7:0] d, input logic l);
        int   n;
        logic eop;
        s_tvalid_i = 1'b1;
        s_tdata_i  = d;
        s_tlast_i  = l;
        n = 0;
        @(negedge clk);
        while (!s_tready_o && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 5000) check("put_timeout", 32'(s_tready_o), 32'd1);
        @(posedge clk);
        #1;
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        if (n < 5000) begin
            eop = l || (ref_len == MAXP - 1);
            exp_q.push_back({eop, d});
            ref_len = eop ? 0 : ref_len + 1;
        end
    endtask

    task automatic wait_await();
        int n = 0;
        while (!awaiting && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!awaiting) check("await_timeout", 32'(awaiting), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        wait_await();
        ack_i = 1'b1;
        @(posedge clk);
        #1;
        ack_i = 1'b0;
    endtask

    task automatic pulse_retry();
        wait_await();
        retry_i = 1'b1;
        @(posedge clk);
        #1;
        retry_i = 1'b0;
    endtask

    initial begin
        int        cyc = 0;
        bit [3:0]  pat = 4'b1001;
        m_tready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rdy_pat) m_tready_i = pat[cyc % 4];
            else m_tready_i = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor: compare every accepted byte, and check outputs hold during stalls.
    initial begin
        bit         prev_stall = 1'b0;
        logic [8:0] prev_out   = '0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", 32'({m_tvalid_o, m_tlast_o, m_tdata_o}),
                          32'({1'b1, prev_out}));
                end
                prev_stall = m_tvalid_o && !m_tready_i && !retry_i;
                prev_out   = {m_tlast_o, m_tdata_o};
                if (m_tvalid_o && m_tready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 32'({m_tlast_o, m_tdata_o}), 32'h200);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_byte", 32'({m_tlast_o, m_tdata_o}), 32'(e));
                        infl_q.push_back(e);
                        if (m_tlast_o) awaiting = 1'b1;
                    end
                end
                if (retry_i) begin
                    while (infl_q.size() > 0) exp_q.push_front(infl_q.pop_back());
                    awaiting = 1'b0;
                end else if (ack_i && awaiting) begin
                    infl_q.delete();
                    awaiting = 1'b0;
                    acked_pkts++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lens[12];
        int total;
        int start_acked;
        int idx;
        int n;
        bit got_last;

        rst_n = 1'b1;
        {s_tvalid_i, s_tlast_i, s_tdata_i, ack_i, retry_i} = '0;
        {sm_s_tvalid, sm_s_tlast, sm_s_tdata, sm_m_tready, sm_ack, sm_retry} = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_tready", 32'(s_tready_o), 32'd1);
        check("rst_has_data", 32'(has_data_o), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid_o), 32'd0);
        check("rst_m_tlast", 32'(m_tlast_o), 32'd0);
        check("rst_m_tdata", 32'(m_tdata_o), 32'd0);
        check("rst_pkt_count", 32'(pkt_count_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Short packet: has_data visible right after commit, then the reader takes it.
        rdy_pct = 100;
        put(8'h01, 1'b0);
        put(8'h02, 1'b0);
        put(8'h03, 1'b0);
        put(8'h04, 1'b1);
        check("short_has_data", 32'(has_data_o), 32'd1);
        check("short_pkt_count", 32'(pkt_count_o), 32'd1);
        @(posedge clk);
        #1;
        check("short_has_data_prefetch", 32'(has_data_o), 32'd0);
        pulse_ack();
        check("short_pkt_after_ack", 32'(pkt_count_o), 32'd0);

        // 1000-byte stream splits into 512 + 488.
        rdy_pct = 0;
        for (int i = 0; i < 1000; i++) put(8'($urandom), i == 999);
        check("split_pkt_count", 32'(pkt_count_o), 32'd2);
        rdy_pct = 100;
        pulse_ack();
        pulse_ack();
        check("split_pkt_after", 32'(pkt_count_o), 32'd0);

        // Retry in WAIT resends the same packet.
        put(8'hA1, 1'b0);
        put(8'hB2, 1'b0);
        put(8'hC3, 1'b1);
        pulse_retry();
        pulse_ack();
        check("retry_pkt_after", 32'(pkt_count_o), 32'd0);

        // Ready pattern 1,0,0,1 across a packet.
        rdy_pat = 1'b1;
        for (int i = 0; i < 6; i++) put(8'(8'h30 + i), i == 5);
        pulse_ack();
        rdy_pat = 1'b0;

        // Randomised traffic with random ready, ACKs and retries.
        total = 0;
        for (int i = 0; i < 12; i++) begin
            lens[i] = ($urandom_range(4) == 0) ? int'($urandom_range(600, 513))
                                               : int'($urandom_range(20, 1));
            total += (lens[i] + MAXP - 1) / MAXP;
        end
        start_acked = acked_pkts;
        rdy_pct = 70;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    for (int j = 0; j < lens[i]; j++) put(8'($urandom), j == lens[i] - 1);
                end
            end
            begin
                int cyc  = 0;
                int rbud = 4;
                while (acked_pkts - start_acked < total && cyc < 30000) begin
                    @(negedge clk);
                    cyc++;
                    if (awaiting) begin
                        @(posedge clk);
                        #1;
                        if ($urandom_range(3) == 0) retry_i = 1'b1;
                        else ack_i = 1'b1;
                        @(posedge clk);
                        #1;
                        ack_i   = 1'b0;
                        retry_i = 1'b0;
                    end else if (m_tvalid_o && rbud > 0 && $urandom_range(199) == 0) begin
                        rbud--;
                        @(posedge clk);
                        #1;
                        retry_i = 1'b1;
                        @(posedge clk);
                        #1;
                        retry_i = 1'b0;
                    end
                end
                check("rand_all_acked", 32'(acked_pkts - start_acked), 32'(total));
            end
        join
        @(posedge clk);
        #1;
        check("rand_pkt_count", 32'(pkt_count_o), 32'd0);
        check("rand_sb_empty", 32'(exp_q.size()), 32'd0);

        // Small buffer: full after 16 bytes, space returns only on ACK.
        sm_m_tready = 1'b0;
        sm_s_tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sm_s_tdata = 8'(i);
            sm_s_tlast = (i == 15);
            @(negedge clk);
            check("sm_ready_filling", 32'(sm_s_tready), 32'd1);
            @(posedge clk);
            #1;
        end
        sm_s_tvalid = 1'b0;
        sm_s_tlast  = 1'b0;
        check("sm_full_ready", 32'(sm_s_tready), 32'd0);
        check("sm_full_pkts", 32'(sm_pkt_count), 32'd2);
        sm_m_tready = 1'b1;
        idx = 0;
        got_last = 1'b0;
        n = 0;
        while (!got_last && n < 40) begin
            @(negedge clk);
            n++;
            if (sm_m_tvalid && sm_m_tready) begin
                check("sm_read_byte", 32'(sm_m_tdata), 32'(idx));
                idx++;
                got_last = sm_m_tlast;
            end
        end
        check("sm_first_len", 32'(idx), 32'd8);
        @(posedge clk);
        #1;
        sm_m_tready = 1'b0;
        repeat (3) @(negedge clk);
        check("sm_ready_before_ack", 32'(sm_s_tready), 32'd0);
        @(posedge clk);
        #1;
        sm_ack = 1'b1;
        @(posedge clk);
        #1;
        sm_ack = 1'b0;
        check("sm_ready_after_ack", 32'(sm_s_tready), 32'd1);
        check("sm_pkts_after_ack", 32'(sm_pkt_count), 32'd1);

        // Reset during SEND with two packets queued.
        rdy_pct = 0;
        for (int i = 0; i < 5; i++) put(8'(8'h50 + i), i == 4);
        for (int i = 0; i < 3; i++) put(8'(8'h60 + i), i == 2);
        n = 0;
        @(negedge clk);
        while (!m_tvalid_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_send_valid_before", 32'(m_tvalid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_m_tvalid", 32'(m_tvalid_o), 32'd0);
        check("rst_mid_pkt_count", 32'(pkt_count_o), 32'd0);
        check("rst_mid_has_data", 32'(has_data_o), 32'd0);
        exp_q.delete();
        infl_q.delete();
        awaiting = 1'b0;
        ref_len  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_has_data", 32'(has_data_o), 32'd0);
        end
        rdy_pct = 100;
        put(8'hAA, 1'b0);
        put(8'h55, 1'b1);
        pulse_ack();
        check("post_rst_pkt_count", 32'(pkt_count_o), 32'd0);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
